// File: rtl/qdiv_arbiter.sv
// Round-robin front end that shares one sequential sign-magnitude fixed-point divider
// among NREQ requesters. It short-circuits zero divisors and aborts a divide that never answers.
module qdiv_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic                  rsp_warn,
  output logic                  busy,
  output logic                  div_start,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_busy,
  input  logic                  div_valid,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic                  div_warn
);

  localparam int          PW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          TW     = $clog2(TIMEOUT);
  localparam int unsigned NREQ_U = NREQ;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [PW-1:0] LAST = PW'(NREQ - 1);

  logic [1:0]       r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_owner;
  logic [TW-1:0]    r_timer;
  logic [NREQ-1:0]  r_gnt;
  logic [WIDTH-1:0] r_quot;
  logic             r_warn;
  logic [WIDTH-1:0] r_dividend;
  logic [WIDTH-1:0] r_divisor;

  logic             w_found;
  logic [PW-1:0]    w_sel;
  logic [PW:0]      w_sum;
  logic [PW-1:0]    w_idx;
  logic [NREQ-1:0]  w_sel_onehot;
  logic [WIDTH-1:0] w_sel_dvd;
  logic [WIDTH-1:0] w_sel_dvs;
  logic             w_dvs_zero;

  // First requester at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int unsigned k = 0; k < NREQ_U; k++) begin
      w_sum = {1'b0, r_ptr} + (PW+1)'(k);
      w_idx = (w_sum >= (PW+1)'(NREQ)) ? PW'(w_sum - (PW+1)'(NREQ)) : PW'(w_sum);
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
  end

  assign w_sel_onehot = NREQ'(1) << w_sel;
  assign w_sel_dvd    = req_dividend[w_sel*WIDTH +: WIDTH];
  assign w_sel_dvs    = req_divisor[w_sel*WIDTH +: WIDTH];
  assign w_dvs_zero   = ~|w_sel_dvs[WIDTH-2:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_ptr      <= '0;
      r_owner    <= '0;
      r_timer    <= '0;
      r_gnt      <= '0;
      r_quot     <= '0;
      r_warn     <= 1'b0;
      r_dividend <= '0;
      r_divisor  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_owner    <= w_sel;
            r_gnt      <= w_sel_onehot;
            r_dividend <= w_sel_dvd;
            r_divisor  <= w_sel_dvs;
            // A zero-magnitude divisor never reaches the divider: saturate with the result sign.
            if (w_dvs_zero) begin
              r_quot  <= {w_sel_dvd[WIDTH-1] ^ w_sel_dvs[WIDTH-1], {(WIDTH-1){1'b1}}};
              r_warn  <= 1'b1;
              r_state <= S_RESP;
            end else begin
              r_state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (!div_busy) begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (div_valid) begin
            r_quot  <= div_quotient;
            r_warn  <= div_warn;
            r_state <= S_RESP;
          end else if (r_timer == TMAX) begin
            r_quot  <= '0;
            r_warn  <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          r_ptr   <= (r_owner == LAST) ? '0 : r_owner + 1'b1;
          r_gnt   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt          = r_gnt;
  assign rsp_valid    = (r_state == S_RESP) ? r_gnt : '0;
  assign rsp_quotient = r_quot;
  assign rsp_warn     = r_warn;
  assign busy         = (r_state != S_IDLE);
  assign div_start    = (r_state == S_ISSUE) && !div_busy;
  assign div_dividend = r_dividend;
  assign div_divisor  = r_divisor;

endmodule

// File: tb/tb_qdiv_arbiter.sv
// Bench for qdiv_arbiter: a 20-cycle sign-magnitude Q15.16 divider model, directed vectors,
// corner-case sequences and a randomized phase checked against a round-robin reference.
module tb_qdiv_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 32;
  localparam int TMO  = 64;
  localparam int LAT  = 20;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [NREQ*W-1:0]   req_dividend;
  logic [NREQ*W-1:0]   req_divisor;
  logic [NREQ-1:0]     gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [W-1:0]        rsp_quotient;
  logic                rsp_warn;
  logic                busy;
  logic                div_start;
  logic [W-1:0]        div_dividend;
  logic [W-1:0]        div_divisor;
  logic                div_busy;
  logic                div_valid;
  logic [W-1:0]        div_quotient;
  logic                div_warn;

  always #5 clk = ~clk;

  qdiv_arbiter #(.NREQ(NREQ), .WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_quotient(rsp_quotient), .rsp_warn(rsp_warn),
    .busy(busy), .div_start(div_start), .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_busy(div_busy), .div_valid(div_valid), .div_quotient(div_quotient), .div_warn(div_warn)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_starts = 0;

  // Sign-magnitude Q15.16 divide; returns {warn, quotient}, saturating on overflow or zero divisor.
  function automatic logic [32:0] qref(input logic [31:0] a, input logic [31:0] b);
    logic [46:0] num, den, quo;
    logic s;
    s = a[31] ^ b[31];
    if (b[30:0] == 31'd0) return {1'b1, s, {31{1'b1}}};
    num = {a[30:0], 16'h0000};
    den = {16'h0000, b[30:0]};
    quo = num / den;
    if (quo[46:31] != 16'h0000) return {1'b1, s, {31{1'b1}}};
    return {1'b0, s, quo[30:0]};
  endfunction

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < NREQ; k++)
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction

  // Divider model
  logic [5:0]  m_cnt   = '0;
  logic        m_valid = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_q = '0;
  logic        m_warn  = 1'b0;
  logic        tb_never = 1'b0, tb_force = 1'b0, tb_inject = 1'b0;

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (div_start) begin
      m_cnt <= 6'(LAT);
      m_a   <= div_dividend;
      m_b   <= div_divisor;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1 && !tb_never) begin
        m_valid        <= 1'b1;
        {m_warn, m_q}  <= qref(m_a, m_b);
      end
    end
  end

  assign div_busy     = (m_cnt != 0) || tb_force;
  assign div_valid    = m_valid || tb_inject;
  assign div_quotient = tb_inject ? 32'hDEADBEEF : m_q;
  assign div_warn     = tb_inject ? 1'b1 : m_warn;

  initial forever begin
    @(posedge clk);
    cyc++;
    if (div_start) n_starts++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, want);
    end
  endtask

  initial forever begin
    @(negedge clk);
    chk("gnt_onehot", 64'($countones(gnt) <= 1), 64'd1);
    chk("rsp_onehot", 64'($countones(rsp_valid) <= 1), 64'd1);
  end

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    req[i] = 1'b1;
    req_dividend[i*W +: W] = a;
    req_divisor[i*W +: W]  = b;
  endtask

  task automatic clr_req(input int i);
    if (i >= 0 && i < NREQ) req[i] = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 64'(gnt), 64'd0);
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({tag, "_rsp_quotient"}, 64'(rsp_quotient), 64'd0);
    chk({tag, "_rsp_warn"}, 64'(rsp_warn), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_div_start"}, 64'(div_start), 64'd0);
    chk({tag, "_div_dividend"}, 64'(div_dividend), 64'd0);
    chk({tag, "_div_divisor"}, 64'(div_divisor), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic wait_rsp(input int budget, input int t0, output int owner,
                          output logic [31:0] q, output logic w, output int lat);
    owner = -1; q = '0; w = 1'b0; lat = -1;
    for (int n = 0; n < budget; n++) begin
      @(posedge clk); #1;
      if (rsp_valid != 0) begin
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) owner = i;
        q   = rsp_quotient;
        w   = rsp_warn;
        lat = cyc - t0;
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL rsp_wait: no rsp_valid within %0d cycles", budget);
  endtask

  typedef struct {
    int          idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic        w;
    int          lat;
    int          starts;
  } vec_t;

  vec_t        tbl[7];
  int          owner, lat, t0, s0, mptr, mowner, nops, e, responded;
  logic [31:0] q;
  logic        w;
  logic [3:0]  prev_gnt;
  logic [31:0] pa[NREQ], pb[NREQ];
  logic [32:0] ref_r;

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{0, 32'h00080000, 32'h00020000, 32'h00040000, 1'b0, 23, 1};
    tbl[1] = '{2, 32'h00070000, 32'h80000000, 32'hFFFFFFFF, 1'b1, 1,  0};
    tbl[2] = '{1, 32'h80060000, 32'h00030000, 32'h80020000, 1'b0, 23, 1};
    tbl[3] = '{3, 32'h7FFF0000, 32'h00000001, 32'h7FFFFFFF, 1'b1, 23, 1};
    tbl[4] = '{0, 32'h00030000, 32'h00000000, 32'h7FFFFFFF, 1'b1, 1,  0};
    tbl[5] = '{1, 32'h80010000, 32'h80040000, 32'h00004000, 1'b0, 23, 1};
    tbl[6] = '{3, 32'h00000000, 32'h00050000, 32'h00000000, 1'b0, 23, 1};

    rst_n = 1'b0;
    req = '0;
    req_dividend = '0;
    req_divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;

    // Directed vectors, one requester at a time
    for (int r = 0; r < 7; r++) begin
      @(posedge clk); #1;
      s0 = n_starts;
      t0 = cyc;
      set_req(tbl[r].idx, tbl[r].a, tbl[r].b);
      wait_rsp(60, t0, owner, q, w, lat);
      clr_req(tbl[r].idx);
      chk($sformatf("vec%0d_owner", r), 64'(owner), 64'(tbl[r].idx));
      chk($sformatf("vec%0d_quot", r), 64'(q), 64'(tbl[r].q));
      chk($sformatf("vec%0d_warn", r), 64'(w), 64'(tbl[r].w));
      chk($sformatf("vec%0d_latency", r), 64'(lat), 64'(tbl[r].lat));
      chk($sformatf("vec%0d_starts", r), 64'(n_starts - s0), 64'(tbl[r].starts));
    end

    // Round-robin order: all four after reset, then 1 and 3 arriving while 2 is served
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, 32'((i + 1) * 32'h00010000), 32'h00010000);
    for (int n = 0; n < NREQ; n++) begin
      wait_rsp(60, cyc, owner, q, w, lat);
      clr_req(owner);
      chk($sformatf("order%0d_owner", n), 64'(owner), 64'(n));
      chk($sformatf("order%0d_quot", n), 64'(q), 64'((n + 1) * 32'h00010000));
    end
    @(posedge clk); #1;
    set_req(2, 32'h000A0000, 32'h00020000);
    for (int n = 0; n < 5 && gnt != 4'b0100; n++) begin
      @(posedge clk); #1;
    end
    chk("order_gnt2", 64'(gnt), 64'h4);
    set_req(1, 32'h000C0000, 32'h00040000);
    set_req(3, 32'h00010000, 32'h00040000);
    wait_rsp(60, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("order_r2_owner", 64'(owner), 64'd2);
    chk("order_r2_quot", 64'(q), 64'h00050000);
    wait_rsp(60, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("order_r3_owner", 64'(owner), 64'd3);
    chk("order_r3_quot", 64'(q), 64'h00004000);
    wait_rsp(60, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("order_r1_owner", 64'(owner), 64'd1);
    chk("order_r1_quot", 64'(q), 64'h00030000);

    // Divider busy for the first 10 cycles of the grant
    @(posedge clk); #1;
    s0 = n_starts;
    set_req(2, 32'h00090000, 32'h00030000);
    tb_force = 1'b1;
    for (int n = 0; n < 10; n++) begin
      @(posedge clk); #1;
      chk("busy_hold_start", 64'(div_start), 64'd0);
      chk("busy_hold_gnt", 64'(gnt), 64'h4);
      chk("busy_hold_dvd", 64'(div_dividend), 64'h00090000);
      chk("busy_hold_dvs", 64'(div_divisor), 64'h00030000);
    end
    tb_force = 1'b0;
    #1;
    chk("busy_release_start", 64'(div_start), 64'd1);
    wait_rsp(60, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("busy_owner", 64'(owner), 64'd2);
    chk("busy_quot", 64'(q), 64'h00030000);
    chk("busy_warn", 64'(w), 64'd0);
    chk("busy_starts", 64'(n_starts - s0), 64'd1);

    // Divider never answers
    @(posedge clk); #1;
    tb_never = 1'b1;
    t0 = cyc;
    set_req(0, 32'h00080000, 32'h00020000);
    wait_rsp(100, t0, owner, q, w, lat);
    clr_req(0);
    tb_never = 1'b0;
    chk("tmo_owner", 64'(owner), 64'd0);
    chk("tmo_quot", 64'(q), 64'd0);
    chk("tmo_warn", 64'(w), 64'd1);
    chk("tmo_latency", 64'(lat), 64'(TMO + 2));
    @(posedge clk); #1;
    tb_inject = 1'b1;
    @(posedge clk); #1;
    tb_inject = 1'b0;
    for (int n = 0; n < 3; n++) begin
      @(posedge clk); #1;
      chk("late_valid_idle", 64'({busy, rsp_valid}), 64'd0);
      chk("late_valid_quot", 64'({rsp_warn, rsp_quotient}), 64'h1_0000_0000);
    end
    t0 = cyc;
    set_req(1, 32'h80060000, 32'h00030000);
    wait_rsp(60, t0, owner, q, w, lat);
    clr_req(1);
    chk("post_tmo_owner", 64'(owner), 64'd1);
    chk("post_tmo_quot", 64'(q), 64'h80020000);
    chk("post_tmo_warn", 64'(w), 64'd0);
    chk("post_tmo_latency", 64'(lat), 64'd23);

    // Reset while waiting on the divider; pointer is at 2 beforehand
    @(posedge clk); #1;
    set_req(0, 32'h00080000, 32'h00020000);
    repeat (8) @(posedge clk);
    #1;
    chk("rst_pre_busy", 64'(busy), 64'd1);
    clr_req(0);
    rst_n = 1'b0;
    #1;
    check_zero("rst_wait");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk); #1;
      chk("stale_ignored", 64'({busy, rsp_valid, rsp_quotient}), 64'd0);
    end
    set_req(1, 32'h00060000, 32'h00020000);
    set_req(3, 32'h00050000, 32'h00010000);
    wait_rsp(80, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("rst_first_owner", 64'(owner), 64'd1);
    chk("rst_first_quot", 64'(q), 64'h00030000);
    wait_rsp(80, cyc, owner, q, w, lat);
    clr_req(owner);
    chk("rst_second_owner", 64'(owner), 64'd3);
    chk("rst_second_quot", 64'(q), 64'h00050000);

    // Randomized traffic against a transaction-level round-robin reference
    @(posedge clk); #1;
    do_reset();
    mptr = 0;
    mowner = -1;
    nops = 0;
    prev_gnt = '0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      responded = -1;
      if (gnt != 0 && prev_gnt == 0) begin
        e = rr_pick(req, mptr);
        chk("rand_gnt", 64'(gnt), (e < 0) ? 64'd0 : (64'd1 << e));
        mowner = e;
        if (e >= 0) begin
          chk("rand_dvd", 64'(div_dividend), 64'(pa[e]));
          chk("rand_dvs", 64'(div_divisor), 64'(pb[e]));
        end
      end
      if (rsp_valid != 0) begin
        chk("rand_rsp_owner", 64'(rsp_valid), (mowner < 0) ? 64'd0 : (64'd1 << mowner));
        if (mowner >= 0) begin
          ref_r = qref(pa[mowner], pb[mowner]);
          chk("rand_quot", 64'(rsp_quotient), 64'(ref_r[31:0]));
          chk("rand_warn", 64'(rsp_warn), 64'(ref_r[32]));
          mptr = (mowner + 1) % NREQ;
          req[mowner] = 1'b0;
          responded = mowner;
          mowner = -1;
        end
        nops++;
      end
      prev_gnt = gnt;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && i != responded && $urandom_range(0, 3) == 0) begin
          pa[i] = $urandom;
          if ($urandom_range(0, 1) == 1) pa[i] = pa[i] & 32'h800FFFFF;
          pb[i] = $urandom;
          case ($urandom_range(0, 7))
            0:       pb[i] = pb[i] & 32'h80000000;
            1, 2:    pb[i] = pb[i] & 32'h800FFFFF;
            default: pb[i] = pb[i] & 32'h803FFFFF;
          endcase
          set_req(i, pa[i], pb[i]);
        end
      end
    end
    req = '0;
    chk("rand_progress", 64'(nops >= 50), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
